// File: rtl/feedback_sched_pkg.sv
// feedback_sched_pkg: shared sizes, FSM states and channel-index type for the feedback scheduler
package feedback_sched_pkg;
  localparam int NCH = 4;
  localparam int W = 8;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  typedef logic [1:0] chan_t;
endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-way round-robin grant, searching upward from ptr with wraparound
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt
);
  // walk offsets from farthest to nearest so the nearest request to ptr wins
  always_comb begin
    gnt = '0;
    for (int i = 3; i >= 0; i--)
      if (req[ptr + 2'(i)]) gnt = 4'b0001 << (ptr + 2'(i));
  end
endmodule

// File: rtl/feedback_scheduler.sv
// feedback_scheduler: per-channel accumulators sharing one adder under round-robin, with sequential flush readout
module feedback_scheduler
  import feedback_sched_pkg::*;
#(
  parameter int NCH = feedback_sched_pkg::NCH,
  parameter int W = feedback_sched_pkg::W
) (
  input  logic                system1000,
  input  logic                system1000_rstn,
  input  logic                enable_i,
  input  logic                flush_i,
  input  logic [NCH-1:0]      req_valid,
  input  logic [NCH*W-1:0]    req_data,
  output logic [NCH-1:0]      req_ready,
  output logic                out_valid,
  output chan_t               out_chan,
  output logic signed [W-1:0] out_data,
  output logic                out_flush,
  output logic                busy_o
);
  state_t state;
  chan_t ptr, fcnt, k;
  logic [3:0] gnt;
  logic signed [W-1:0] acc [NCH];
  logic signed [W-1:0] din, sum;
  rr_arbiter4 u_arb (
    .req(req_valid),
    .ptr(ptr),
    .gnt(gnt)
  );
  // grant only while running; the granted channel feeds the single shared adder
  always_comb begin
    req_ready = (state == RUN) ? gnt : '0;
    k = {req_ready[3] | req_ready[2], req_ready[3] | req_ready[1]};
    din = req_data[k*W +: W];
    sum = acc[k] + din;
  end
  // FSM, accumulator bank and registered result port
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state <= IDLE;
      ptr <= '0;
      fcnt <= '0;
      out_valid <= 1'b0;
      out_chan <= '0;
      out_data <= '0;
      out_flush <= 1'b0;
      busy_o <= 1'b0;
      for (int i = 0; i < NCH; i++) acc[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (enable_i) state <= RUN;
        RUN: begin
          if (|req_ready) begin
            acc[k] <= sum;
            ptr <= k + 2'd1;
            out_valid <= 1'b1;
            out_chan <= k;
            out_data <= sum;
            out_flush <= 1'b0;
          end
          if (flush_i) begin
            state <= FLUSH;
            fcnt <= '0;
            busy_o <= 1'b1;
          end else if (!enable_i) state <= IDLE;
        end
        FLUSH: begin
          out_valid <= 1'b1;
          out_chan <= fcnt;
          out_data <= acc[fcnt];
          out_flush <= 1'b1;
          acc[fcnt] <= '0;
          fcnt <= fcnt + 2'd1;
          if (fcnt == 2'd3) begin
            state <= enable_i ? RUN : IDLE;
            busy_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
